// File: rtl/dac_6b_if.sv
// rtl/dac_6b_if.sv - handshake and output bundle for the 6-bit behavioural DAC
//
// Purpose: groups the request handshake, power-down and DAC outputs so the
//          requester and the DAC connect through a single port.
// Signals:
//   pd        power down, sampled at posedge by the DAC
//   code      requested 6-bit code
//   valid     code is valid
//   ready     DAC can accept a code this cycle
//   busy      DAC is slewing or settling
//   done      one-cycle completion pulse
//   cur_code  present output code
//   out       analog output level (real)
// Modports: master = requester side, slave = DAC side.

interface dac_6b_if;
  logic       pd;
  logic [5:0] code;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic [5:0] cur_code;
  real        out;

  modport master (
    output pd, code, valid,
    input  ready, busy, done, cur_code, out
  );

  modport slave (
    input  pd, code, valid,
    output ready, busy, done, cur_code, out
  );
endinterface

// File: rtl/dac_6b.sv
// rtl/dac_6b.sv - behavioural 6-bit DAC with bounded slew and settle hold
//
// Purpose: accepts a code over valid/ready, moves cur_code toward it, holds
//          for SETTLE_CYC cycles, then pulses done. out sits at the centre of
//          each quantisation bin so a loopback through the 6-bit ADC model
//          returns the original code.
// Ports:
//   clk   clock, all state updates on posedge
//   rstn  asynchronous active-low reset
//   bus   dac_6b_if.slave (pd, code, valid, ready, busy, done, cur_code, out)
// Parameters: VH, VL (full-scale range), MAX_STEP (code change per clock,
//             1..63), SETTLE_CYC (hold cycles, 0..255).
// Build option: DAC_6B_SLEW_EN - when defined, cur_code moves at most
//               MAX_STEP per clock; when undefined it jumps to the target on
//               the first slew edge.

module dac_6b #(
  parameter real VH         = 3.0,
  parameter real VL         = -3.0,
  parameter int  MAX_STEP   = 4,
  parameter int  SETTLE_CYC = 3
) (
  input  logic     clk,
  input  logic     rstn,
  dac_6b_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SLEW   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  localparam real STEP = (VH - VL) / 64.0;

  logic [1:0] state;
  logic [5:0] tgt;
  logic [5:0] cur;
  logic [7:0] cnt;
  logic       done_r;
  logic [5:0] next_code;

  function automatic real level(input logic [5:0] c);
    return VL + (real'(c) + 0.5) * STEP;
  endfunction

`ifdef DAC_6B_SLEW_EN
  localparam logic signed [6:0] STEP_MAX = 7'(MAX_STEP);

  // Distance is taken at 7-bit signed width so 0..63 differences never wrap;
  // when the remaining distance is within one step we land exactly on tgt.
  logic signed [6:0] dist;

  always_comb begin
    dist      = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    next_code = tgt;
    if (dist > STEP_MAX)
      next_code = cur + 6'(MAX_STEP);
    else if (dist < -STEP_MAX)
      next_code = cur - 6'(MAX_STEP);
  end
`else
  assign next_code = tgt;
`endif

  assign bus.ready    = (state == S_IDLE) && !bus.pd;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = done_r;
  assign bus.cur_code = cur;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      tgt     <= 6'd0;
      cnt     <= 8'd0;
      cur     <= 6'd0;
      done_r  <= 1'b0;
      bus.out <= level(6'd0);
    end else if (bus.pd) begin
      // Power down aborts any transfer; out parks at 0 V rather than code 0.
      state   <= S_IDLE;
      cur     <= 6'd0;
      done_r  <= 1'b0;
      bus.out <= 0.0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // Re-deriving out here restores the code level on the first edge
          // after power down is released.
          bus.out <= level(cur);
          if (bus.valid) begin
            tgt   <= bus.code;
            state <= S_SLEW;
          end
        end
        S_SLEW: begin
          cur     <= next_code;
          bus.out <= level(next_code);
          if (next_code == tgt) begin
            state <= S_SETTLE;
            cnt   <= 8'(SETTLE_CYC);
          end
        end
        S_SETTLE: begin
          if (cnt == 8'd0) begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_6b.sv
// tb/tb_dac_6b.sv - scoreboard testbench for dac_6b

module tb_dac_6b;

`ifdef DAC_6B_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  typedef struct {
    int  code;
    real out;
    int  cyc;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  dac_6b_if bus ();

  dac_6b dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    real d;
    n_checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > 1.0e-9) begin
      n_fail++;
      $display("FAIL %s: got %f expected %f", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && bus.done) begin
      if (sb.size() == 0) begin
        check_int("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_int("done_cur_code", int'(bus.cur_code), e.code);
        check_real("done_out", bus.out, e.out);
        check_int("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; presents a code for one accepting edge.
  task automatic accept(input int code, input real out_exp, input int l_slew,
                        input int l_flat, input bit push);
    exp_t e;
    bus.code  = 6'(code);
    bus.valid = 1'b1;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    if (push) begin
      e.code = code;
      e.out  = out_exp;
      e.cyc  = cyc + (SLEW ? l_slew : l_flat);
      sb.push_back(e);
    end
  endtask

  // Returns at the negedge of the done cycle.
  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) check_int("done_timeout", 0, 1);
  endtask

  initial begin
    exp_t e;
    int   kmax;
    int   pd_edge;
    int   exp_c;
    n_checks  = 0;
    n_fail    = 0;
    bus.pd    = 1'b0;
    bus.valid = 1'b0;
    bus.code  = 6'd0;
    rstn      = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_int("rst_cur_code", int'(bus.cur_code), 0);
    check_real("rst_out", bus.out, -2.953125);
    check_int("rst_ready", int'(bus.ready), 1);
    check_int("rst_busy", int'(bus.busy), 0);
    check_int("rst_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // 0 -> 63: slewing 4 per edge reaches 63 at E16, done after E20.
    accept(63, 2.953125, 20, 5, 1'b1);
    kmax = SLEW ? 16 : 1;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      #1;
      exp_c = SLEW ? ((4 * k > 63) ? 63 : 4 * k) : 63;
      check_int("slew_cur_code", int'(bus.cur_code), exp_c);
    end
    wait_done();

    // 63 -> 40: distance 23, n = 6.
    accept(40, 0.796875, 10, 5, 1'b1);
    wait_done();

    // 40 -> 40: no move, straight to settle.
    accept(40, 0.796875, 5, 5, 1'b1);
    @(posedge clk);
    #1;
    check_real("same_code_out", bus.out, 0.796875);
    check_int("same_code_busy", int'(bus.busy), 1);
    wait_done();

    // 40 -> 20, with a competing request held while busy; that request is
    // only taken in the done cycle, where it starts 20 -> 10 (n = 3).
    accept(20, -1.078125, 9, 5, 1'b1);
    @(negedge clk);
    bus.code  = 6'd10;
    bus.valid = 1'b1;
    check_int("busy_ready", int'(bus.ready), 0);
    wait_done();
    check_int("donecyc_ready", int'(bus.ready), 1);
    check_int("donecyc_busy", int'(bus.busy), 0);
    e.code = 10;
    e.out  = -2.015625;
    e.cyc  = cyc + 1 + (SLEW ? 7 : 5);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    check_int("reaccept_busy", int'(bus.busy), 1);
    wait_done();

    // 10 -> 0: n = 3.
    accept(0, -2.953125, 7, 5, 1'b1);
    wait_done();

    // 0 -> 63 aborted by power down before completion.
    accept(63, 0.0, 20, 5, 1'b0);
    pd_edge = SLEW ? 8 : 3;
    repeat (pd_edge) @(negedge clk);
    bus.pd = 1'b1;
    @(posedge clk);
    #1;
    check_real("pd_out", bus.out, 0.0);
    check_int("pd_cur_code", int'(bus.cur_code), 0);
    check_int("pd_ready", int'(bus.ready), 0);
    check_int("pd_busy", int'(bus.busy), 0);
    repeat (6) @(negedge clk);
    check_int("pd_done", int'(bus.done), 0);
    bus.pd = 1'b0;
    @(posedge clk);
    #1;
    check_real("pd_release_out", bus.out, -2.953125);
    check_int("pd_release_ready", int'(bus.ready), 1);

    repeat (4) @(negedge clk);
    check_int("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
